// File: rtl/logs_pwm_decoder.sv
// logs_pwm_decoder
// Integrates a 1-bit PWM line over frames of 2^K cycles and converts the
// high-cycle count back to the transmitting mixer's level. Each recovered
// sample is presented on a valid/ready interface. A sticky overrun flag
// records any unconsumed sample that was overwritten.
module logs_pwm_decoder #(
    parameter int K     = 2,
    parameter int DELAY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         audio_in,
    output logic [K-1:0] sample,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic         overrun
);

    typedef enum logic {
        ST_ALIGN = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // With no alignment delay the first post-reset edge already samples.
    localparam state_t     ST_START   = (DELAY == 0) ? ST_ACCUM : ST_ALIGN;
    localparam logic [3:0] ALIGN_LAST = (DELAY == 0) ? 4'd0 : 4'(DELAY - 1);

    state_t       r_state;
    logic [3:0]   r_align_cnt;
    logic [K-1:0] r_phase;
    logic [K:0]   r_acc;
    logic [K-1:0] r_sample;
    logic         r_valid;
    logic         r_overrun;

    logic [K:0]   w_h;
    logic         w_frame_end;
    logic [K-1:0] w_new_sample;
    logic         w_xfer;

    // High count including the current edge; only meaningful at frame end.
    assign w_h         = r_acc + {{K{1'b0}}, audio_in};
    assign w_frame_end = (r_state == ST_ACCUM) && (r_phase == {K{1'b1}});
    // 2^K-1-h is the bitwise inverse of h's low K bits; a full frame
    // (h = 2^K, top bit set) saturates to zero.
    assign w_new_sample = w_h[K] ? {K{1'b0}} : ~w_h[K-1:0];
    assign w_xfer       = r_valid & sample_ready;

    // Alignment, frame integration and output handshake in one state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_START;
            r_align_cnt <= 4'd0;
            r_phase     <= {K{1'b0}};
            r_acc       <= {(K+1){1'b0}};
            r_sample    <= {K{1'b0}};
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                ST_ALIGN: begin
                    // audio_in is deliberately ignored while aligning.
                    r_align_cnt <= r_align_cnt + 4'd1;
                    if (r_align_cnt == ALIGN_LAST) begin
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    r_phase <= r_phase + {{(K-1){1'b0}}, 1'b1};
                    if (w_frame_end) begin
                        r_acc <= {(K+1){1'b0}};
                    end else begin
                        r_acc <= w_h;
                    end
                end
                default: begin
                    r_state <= ST_START;
                end
            endcase

            // A frame-end load wins over a transfer: valid stays high.
            if (w_frame_end) begin
                r_sample <= w_new_sample;
                r_valid  <= 1'b1;
                if (r_valid && !sample_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_logs_pwm_decoder.sv
// Randomized bench for logs_pwm_decoder. Two instances run side by side:
// A (K=2, DELAY=1) and B (K=3, DELAY=0). A frame-arithmetic reference model
// predicts sample/valid/overrun after every edge.
module tb_logs_pwm_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       audio_a, audio_b;
    logic       ready_a, ready_b;
    logic [1:0] sample_a;
    logic [2:0] sample_b;
    logic       valid_a, valid_b;
    logic       ovr_a, ovr_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    logs_pwm_decoder #(.K(2), .DELAY(1)) dut_a (
        .clk(clk), .reset(reset), .audio_in(audio_a), .sample(sample_a),
        .sample_valid(valid_a), .sample_ready(ready_a), .overrun(ovr_a)
    );

    logs_pwm_decoder #(.K(3), .DELAY(0)) dut_b (
        .clk(clk), .reset(reset), .audio_in(audio_b), .sample(sample_b),
        .sample_valid(valid_b), .sample_ready(ready_b), .overrun(ovr_b)
    );

    // Reference model state, index 0 = A, 1 = B.
    int len [2] = '{4, 8};
    int dly [2] = '{1, 0};
    int m_edge   [2] = '{0, 0};   // edges seen since reset release
    int m_ones   [2] = '{0, 0};   // high edges in the current frame
    int m_sample [2] = '{0, 0};
    bit m_valid  [2] = '{0, 0};
    bit m_ovr    [2] = '{0, 0};

    int cyc;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Position within the frame of the upcoming edge (-1 while still aligning).
    function automatic int next_pos(input int d);
        if (m_edge[d] < dly[d]) return -1;
        return (m_edge[d] - dly[d]) % len[d];
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input int d, input bit rst, input bit aud, input bit rdy);
        int  pos;
        int  h;
        int  nsmp;
        bit  fe;
        if (rst) begin
            m_edge[d] = 0; m_ones[d] = 0; m_sample[d] = 0;
            m_valid[d] = 0; m_ovr[d] = 0;
            return;
        end
        fe   = 0;
        nsmp = 0;
        pos  = next_pos(d);
        if (pos >= 0) begin
            m_ones[d] += int'(aud);
            if (pos == len[d] - 1) begin
                fe = 1;
                h = m_ones[d];
                m_ones[d] = 0;
                nsmp = (h == len[d]) ? 0 : len[d] - 1 - h;
            end
        end
        m_edge[d]++;
        if (m_valid[d] && rdy)
            $display("xfer dut%s cycle=%0d sample=%0d", (d == 0) ? "A" : "B", cyc, m_sample[d]);
        if (fe) begin
            if (m_valid[d] && !rdy) m_ovr[d] = 1;
            m_valid[d]  = 1;
            m_sample[d] = nsmp;
        end else if (m_valid[d] && rdy) begin
            m_valid[d] = 0;
        end
    endtask

    initial begin
        int aud_mode [2];
        int rdy_mode [2];
        int pat_n    [2];
        int rst_left;
        bit aud [2];
        bit rdy [2];
        int pos;

        rst_left = 3;
        cyc      = 0;
        reset    = 1'b1;
        audio_a  = 1'b0; audio_b = 1'b0;
        ready_a  = 1'b0; ready_b = 1'b0;
        aud_mode = '{0, 0};
        rdy_mode = '{0, 0};
        pat_n    = '{0, 0};
        model_step(0, 1'b1, 1'b0, 1'b0);
        model_step(1, 1'b1, 1'b0, 1'b0);

        for (cyc = 1; cyc < 2400; cyc++) begin
            @(negedge clk);
            check_val("a_sample",  int'(sample_a), m_sample[0]);
            check_val("a_valid",   int'(valid_a),  int'(m_valid[0]));
            check_val("a_overrun", int'(ovr_a),    int'(m_ovr[0]));
            check_val("b_sample",  int'(sample_b), m_sample[1]);
            check_val("b_valid",   int'(valid_b),  int'(m_valid[1]));
            check_val("b_overrun", int'(ovr_b),    int'(m_ovr[1]));

            // New traffic pattern every 48 cycles.
            if (cyc % 48 == 1) begin
                for (int d = 0; d < 2; d++) begin
                    aud_mode[d] = $urandom_range(0, 3);
                    rdy_mode[d] = $urandom_range(0, 3);
                    pat_n[d]    = $urandom_range(0, len[d]);
                end
            end

            if (rst_left == 0 && $urandom_range(0, 99) == 0)
                rst_left = $urandom_range(1, 3);
            reset = (rst_left > 0);
            if (rst_left > 0) rst_left--;

            for (int d = 0; d < 2; d++) begin
                pos = next_pos(d);
                case (aud_mode[d])
                    0:       aud[d] = 1'b0;
                    1:       aud[d] = 1'b1;
                    2:       aud[d] = 1'($urandom_range(0, 1));
                    default: aud[d] = (pos >= 0) && (pos < pat_n[d]);
                endcase
                case (rdy_mode[d])
                    0:       rdy[d] = 1'b1;
                    1:       rdy[d] = 1'b0;
                    2:       rdy[d] = 1'($urandom_range(0, 1));
                    default: rdy[d] = (pos == len[d] - 1);
                endcase
            end
            audio_a = aud[0]; ready_a = rdy[0];
            audio_b = aud[1]; ready_b = rdy[1];
            model_step(0, reset, aud[0], rdy[0]);
            model_step(1, reset, aud[1], rdy[1]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/logs_pwm_decoder.md
# logs_pwm_decoder

Recovers the multi-level value carried by a 1-bit PWM audio line produced by `logs_mixer`. It integrates the line over fixed frames of 2^K clock cycles and converts the high-cycle count back to the mixer's `sum` value. Each recovered sample goes out on a valid/ready interface. It sits on the receive side of the audio path: loopback test harnesses and downstream level meters.

## Interface
- `K`, default 2: frame length is 2^K cycles; sample width is K bits. Must match the transmitting mixer.
- `DELAY`, default 1: number of clock edges after reset deassertion that are discarded before frame 0 begins, range 0..15. The value 1 aligns with a `logs_mixer` reset on the same cycle.
- `clk` input 1: clock. One clock domain; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `audio_in` input 1: PWM line. Synchronous to `clk`; sampled directly, with no synchronizer.
- `sample` output K: recovered value, registered.
- `sample_valid` output 1: `sample` holds an unconsumed value.
- `sample_ready` input 1: consumer accepts `sample` on any edge where `sample_valid` and `sample_ready` are both 1.
- `overrun` output 1: sticky flag; an unconsumed sample was overwritten.

## Operation
- States:
  - ALIGN: counts discarded edges up to `DELAY`.
  - ACCUM: integrates frames.
- Reset: state ← ALIGN (or ACCUM directly if `DELAY`=0); align counter, phase counter, and accumulator ← 0. `sample` ← 0, `sample_valid` ← 0, `overrun` ← 0.
- ALIGN: each edge increments the align counter. On the edge where the count reaches `DELAY`-1, go to ACCUM. `audio_in` is ignored on these edges.
- ACCUM, each edge:
  - Phase counter (K bits) increments and wraps.
  - Accumulator (K+1 bits) adds `audio_in`.
- Frame end is the edge where phase = 2^K-1. On that edge:
  - h = accumulator + `audio_in`, range 0..2^K.
  - `sample` ← 2^K-1-h. If h = 2^K, saturate `sample` to 0.
  - Accumulator ← 0; phase wraps to 0.
  - `sample_valid` ← 1.
- Inverse relation: the mixer drives high while its counter > sum, so h = 2^K-1-sum.
- Handshake:
  - Transfer occurs on any edge with `sample_valid` & `sample_ready`.
  - Without a new load on that edge, `sample_valid` ← 0 and `sample` holds its value.
  - `sample_ready` is ignored while `sample_valid` = 0.
- Simultaneous frame end and transfer: the new sample loads and `sample_valid` stays 1. No overrun.
- Frame end while `sample_valid` = 1 and `sample_ready` = 0: the new sample overwrites, `sample_valid` stays 1, and `overrun` ← 1.
- `overrun` clears only on `reset`.
- Reset mid-frame: the partial frame is discarded, no sample is emitted, and `DELAY` is reapplied after release.

## Timing
- First sampled edge of frame 0: edge number `DELAY`, counting the first edge with `reset` = 0 as edge 0.
- Frame f covers edges `DELAY` + f·2^K through `DELAY` + f·2^K + 2^K-1.
- Latency: `sample_valid` rises in the cycle after the frame's last sampling edge. It is registered; there are no combinational paths from inputs to outputs.
- Throughput: one sample per 2^K cycles. The consumer has 2^K cycles to accept each sample before an overrun.
- With K=2 and `DELAY`=1, the first `sample_valid` is visible after edge 4.

## Test plan
- Loopback with `logs_mixer` (N=3, K=2), both reset together, `DELAY`=1, `sample_ready` = 1:
  - Mixer sum = 1 gives `sample` = 1 every 4 cycles.
  - Mixer sum = 3 gives `sample` = 3.
  - `overrun` stays 0.
- `audio_in` held at 0, K=2: `sample` = 3. Held at 1: h = 4 saturates, `sample` = 0.
- `sample_ready` = 0 for 10 cycles from reset release:
  - First sample is visible after edge 4.
  - Second sample overwrites it after edge 8 and `overrun` = 1.
  - `overrun` stays 1 after `ready` returns, until `reset`.
- `sample_ready` pulsed high on exactly a frame-end edge with `sample_valid` = 1: the new sample loads, `sample_valid` is continuously 1, and `overrun` = 0.
- `reset` asserted on phase 2 of frame 1, held for 2 cycles, then released:
  - No sample is emitted for the partial frame.
  - The next `sample_valid` is seen after edge 4 relative to release.
  - All outputs read 0 during reset.
- `DELAY`=0, K=3, `audio_in` high for exactly the first 5 edges of each frame: `sample` = 2, valid after edge 7.
